// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and the RAM model handshake state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/dp_types_pkg.sv
// Datapath-side types; arbiter state is exported so checkers can observe it.
package dp_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Request/response bundle between datapath, arbiter and RAM model.
// Handshake: a request is sampled only while the arbiter is IDLE; the requester
// keeps it asserted until the one-cycle ihit/dhit pulse, then drops it.
interface memory_arbiter_if (
    input logic CLK,
    input logic nRST
);
    logic                   halt;
    logic                   iREN;
    logic                   dREN;
    logic                   dWEN;
    cpu_types_pkg::word_t   iaddr;
    cpu_types_pkg::word_t   daddr;
    cpu_types_pkg::word_t   dstore;
    logic                   ihit;
    logic                   dhit;
    logic                   merr;
    cpu_types_pkg::word_t   iload;
    cpu_types_pkg::word_t   dload;
    logic                   ramREN;
    logic                   ramWEN;
    cpu_types_pkg::word_t   ramaddr;
    cpu_types_pkg::word_t   ramstore;
    cpu_types_pkg::word_t   ramload;
    cpu_types_pkg::ramstate_t ramstate;

    modport arb (
        input  CLK, nRST, halt, iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output ihit, dhit, merr, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport tb (
        input  CLK, nRST, ihit, dhit, merr, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
        output halt, iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate
    );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data port wins over instruction port, one access at a
// time, one-cycle hit pulse with registered load data, error/timeout reporting.
module memory_arbiter
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter int    TIMEOUT = 64,
    parameter word_t ERRWORD = 32'hBAD1BAD1
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       halt,
    input  logic       iREN,
    input  word_t      iaddr,
    input  logic       dREN,
    input  logic       dWEN,
    input  word_t      daddr,
    input  word_t      dstore,
    output logic       ihit,
    output logic       dhit,
    output word_t      iload,
    output word_t      dload,
    output logic       merr,
    output logic       ramREN,
    output logic       ramWEN,
    output word_t      ramaddr,
    output word_t      ramstore,
    input  word_t      ramload,
    input  ramstate_t  ramstate,
    output arb_state_t arb_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state;
    logic [CW-1:0] count;
    word_t         lat_addr;
    word_t         lat_store;
    logic          lat_write;
    logic          lat_dport;

    logic          acc_done;
    logic          resp_err;
    word_t         resp_word;

    // Anything other than ACCESS that ends an access (ERROR or timeout) is an error.
    always_comb begin
        acc_done  = 1'b0;
        resp_err  = 1'b0;
        resp_word = '0;
        acc_done  = (ramstate == ACCESS) || (ramstate == ERROR) || (count == CW'(TIMEOUT - 1));
        resp_err  = (ramstate != ACCESS);
        if (resp_err)
            resp_word = ERRWORD;
        else if (!lat_write)
            resp_word = ramload;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            count     <= '0;
            lat_addr  <= '0;
            lat_store <= '0;
            lat_write <= 1'b0;
            lat_dport <= 1'b0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            merr      <= 1'b0;
            iload     <= '0;
            dload     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    ihit  <= 1'b0;
                    dhit  <= 1'b0;
                    merr  <= 1'b0;
                    iload <= '0;
                    dload <= '0;
                    // A combined dREN/dWEN is a write; halt only gates fetches.
                    if (dWEN || dREN) begin
                        state     <= DACC;
                        lat_addr  <= daddr;
                        lat_store <= dstore;
                        lat_write <= dWEN;
                        lat_dport <= 1'b1;
                    end else if (iREN && !halt) begin
                        state     <= IACC;
                        lat_addr  <= iaddr;
                        lat_store <= '0;
                        lat_write <= 1'b0;
                        lat_dport <= 1'b0;
                    end
                end
                IACC, DACC: begin
                    if (count != CW'(TIMEOUT))
                        count <= count + 1'b1;
                    if (acc_done) begin
                        state <= RESP;
                        ihit  <= !lat_dport;
                        dhit  <= lat_dport;
                        merr  <= resp_err;
                        iload <= lat_dport ? '0 : resp_word;
                        dload <= lat_dport ? resp_word : '0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    count <= '0;
                    ihit  <= 1'b0;
                    dhit  <= 1'b0;
                    merr  <= 1'b0;
                    iload <= '0;
                    dload <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM side is decoded from state and latched request only, never live inputs.
    assign ramREN    = (state == IACC) || ((state == DACC) && !lat_write);
    assign ramWEN    = (state == DACC) && lat_write;
    assign ramaddr   = lat_addr;
    assign ramstore  = lat_store;
    assign arb_state = state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: transaction-level model with a response queue,
// directed scenarios with literal expectations, then randomized traffic.
module tb_memory_arbiter;
    import cpu_types_pkg::*;
    import dp_types_pkg::*;

    localparam int    TO   = 4;
    localparam word_t ERRW = 32'hBAD1BAD1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_arbiter_if bus (.CLK(clk), .nRST(rst_n));

    logic       ihit, dhit, merr, ramREN, ramWEN;
    word_t      iload, dload, ramaddr, ramstore;
    arb_state_t arb_state;

    memory_arbiter #(.TIMEOUT(TO), .ERRWORD(ERRW)) dut (
        .CLK(clk), .nRST(rst_n), .halt(bus.halt),
        .iREN(bus.iREN), .iaddr(bus.iaddr),
        .dREN(bus.dREN), .dWEN(bus.dWEN), .daddr(bus.daddr), .dstore(bus.dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .merr(merr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(bus.ramload), .ramstate(bus.ramstate), .arb_state(arb_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.halt     = 1'b0;
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic settle();
        idle_inputs();
        repeat (3) step();
    endtask

    // ---------------- reference model + scoreboard ----------------
    // A request taken while free occupies the RAM until ACCESS/ERROR or TO cycles,
    // then exactly one response cycle follows. exp_q holds {is_data, err, word}.
    logic [33:0] exp_q[$];
    bit          m_active = 0;
    bit          m_resp   = 0;
    bit          cur_d, cur_w;
    word_t       cur_addr, cur_store;
    int          m_age;

    always @(negedge clk) begin : compare
        logic [159:0] a_ram, e_ram, e_hit;
        logic [33:0]  r;
        if (!rst_n) begin
            m_active = 0;
            m_resp   = 0;
            m_age    = 0;
            exp_q.delete();
            check("reset_outputs",
                  {ihit, dhit, merr, iload, dload, ramREN, ramWEN, ramaddr, ramstore}, '0);
        end else begin
            a_ram = {ramREN, ramWEN, (m_active ? ramaddr : 32'h0),
                     ((m_active && cur_w) ? ramstore : 32'h0)};
            e_ram = '0;
            if (m_active)
                e_ram = {!cur_w, cur_w, cur_addr, (cur_w ? cur_store : 32'h0)};
            check("ram_side", a_ram, e_ram);

            e_hit = '0;
            if (m_resp) begin
                check("resp_queued", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    e_hit = {!r[33], r[33], r[32], (r[33] ? 32'h0 : r[31:0]), (r[33] ? r[31:0] : 32'h0)};
                end
            end
            check("hit_side", {ihit, dhit, merr, iload, dload}, e_hit);

            if (m_resp) begin
                m_resp = 0;
            end else if (m_active) begin
                m_age++;
                if (bus.ramstate == ACCESS) begin
                    exp_q.push_back({cur_d, 1'b0, (cur_w ? 32'h0 : bus.ramload)});
                    m_active = 0;
                    m_resp   = 1;
                end else if (bus.ramstate == ERROR || m_age >= TO) begin
                    exp_q.push_back({cur_d, 1'b1, ERRW});
                    m_active = 0;
                    m_resp   = 1;
                end
            end else if (bus.dREN || bus.dWEN) begin
                cur_d = 1; cur_w = bus.dWEN; cur_addr = bus.daddr; cur_store = bus.dstore;
                m_active = 1; m_age = 0;
            end else if (bus.iREN && !bus.halt) begin
                cur_d = 0; cur_w = 0; cur_addr = bus.iaddr; cur_store = '0;
                m_active = 1; m_age = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int rs;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        at_neg();
        check("reset_state_idle", arb_state, IDLE);
        settle();

        // Fetch, minimum latency, single pulse
        bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = ACCESS; bus.ramload = 32'h2402_0005;
        step(); bus.iREN = 0;
        at_neg();
        check("t1_ren", ramREN, 1);
        check("t1_addr", ramaddr, 32'h40);
        check("t1_no_early_hit", ihit, 0);
        step(); at_neg();
        check("t1_ihit", {ihit, dhit, merr}, 3'b100);
        check("t1_iload", iload, 32'h2402_0005);
        step(); at_neg();
        check("t1_one_pulse", {ihit, iload}, 0);
        settle();

        // Data beats instruction; fetch follows three cycles after dhit
        bus.iREN = 1; bus.iaddr = 32'h200; bus.dREN = 1; bus.daddr = 32'h100;
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFE_F00D;
        step(); bus.dREN = 0;
        at_neg();
        check("t2_daddr_first", {ramREN, ramaddr}, {1'b1, 32'h100});
        step(); bus.ramload = 32'h1111_2222;
        at_neg();
        check("t2_dhit", {ihit, dhit, dload}, {2'b01, 32'hCAFE_F00D});
        step(); at_neg();
        check("t2_gap_idle", ihit, 0);
        step(); at_neg();
        check("t2_fetch_addr", ramaddr, 32'h200);
        step(); bus.iREN = 0;
        at_neg();
        check("t2_ihit", {ihit, iload}, {1'b1, 32'h1111_2222});
        settle();

        // Write with two BUSY cycles
        bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h1234_5678; bus.ramstate = BUSY;
        step(); bus.dWEN = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.ramstate = ACCESS;
            at_neg();
            check("t3_wen_held", {ramWEN, ramREN, ramstore}, {2'b10, 32'h1234_5678});
            step();
        end
        at_neg();
        check("t3_write_resp", {dhit, merr, dload}, {2'b10, 32'h0});
        settle();

        // RAM error on a data read
        bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = ERROR;
        step(); bus.dREN = 0;
        step(); at_neg();
        check("t4_err_resp", {dhit, merr, dload}, {2'b11, 32'hBAD1BAD1});
        settle();

        // Timeout with RAM stuck BUSY
        bus.iREN = 1; bus.iaddr = 32'h44; bus.ramstate = BUSY;
        step(); bus.iREN = 0;
        for (int k = 0; k < TO; k++) begin
            at_neg();
            check("t4_timeout_wait", ihit, 0);
            step();
        end
        at_neg();
        check("t4_timeout_resp", {ihit, merr, iload}, {2'b11, 32'hBAD1BAD1});
        settle();

        // Halt blocks fetches but not data
        bus.halt = 1; bus.iREN = 1; bus.iaddr = 32'h700; bus.ramstate = ACCESS;
        for (int k = 0; k < 10; k++) begin
            at_neg();
            check("t5_halt_no_ren", ramREN, 0);
            step();
        end
        bus.dREN = 1; bus.daddr = 32'h500; bus.ramload = 32'h55;
        step(); bus.dREN = 0;
        at_neg();
        check("t5_data_ok", {ramREN, ramaddr}, {1'b1, 32'h500});
        step(); at_neg();
        check("t5_dhit", {dhit, dload}, {1'b1, 32'h55});
        step(); step(); at_neg();
        check("t5_still_halted", {ramREN, ihit}, 0);
        settle();

        // Asynchronous reset in the middle of a data access
        bus.dREN = 1; bus.daddr = 32'h600; bus.ramstate = BUSY;
        step(); bus.dREN = 0;
        at_neg();
        check("t6_in_access", ramREN, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_async_en", {ramREN, ramWEN}, 0);
        check("t6_state", arb_state, IDLE);
        step(); step();
        rst_n = 1'b1; bus.ramstate = ACCESS;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("t6_no_dhit", dhit, 0);
            step();
        end
        settle();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.halt   = ($urandom_range(0, 4) == 0);
            bus.iREN   = $urandom_range(0, 1);
            bus.dREN   = ($urandom_range(0, 3) == 0);
            bus.dWEN   = ($urandom_range(0, 4) == 0);
            bus.iaddr  = $urandom;
            bus.daddr  = $urandom;
            bus.dstore = $urandom;
            bus.ramload = $urandom;
            rs = $urandom_range(0, 9);
            if (rs <= 2)      bus.ramstate = ACCESS;
            else if (rs <= 6) bus.ramstate = BUSY;
            else if (rs <= 8) bus.ramstate = FREE;
            else              bus.ramstate = ERROR;
        end

        settle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Responder side of the datapath memory-request interface, serving the instruction port (iREN) and the data port (dREN/dWEN, produced by the decoder) toward a single-port RAM.
- Holds a request in latched registers, waits on the RAM handshake, returns one-cycle ihit/dhit pulses with registered load data, and flags RAM errors and timeouts.
- Sits between the datapath/request logic and the RAM model.

Parameters:
TIMEOUT, 64, maximum cycles in an access state without ramstate==ACCESS before the access is aborted with error
ERRWORD, 32'hBAD1BAD1, value returned on iload/dload for an errored access

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
halt  in  1  datapath halted; new instruction fetches are blocked
iREN  in  1  instruction read request
iaddr  in  32  instruction word address
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  32  data address
dstore  in  32  data write value
ihit  out  1  one-cycle instruction response pulse
dhit  out  1  one-cycle data response pulse
iload  out  32  instruction word, valid while ihit=1
dload  out  32  data read word, valid while dhit=1
merr  out  1  one-cycle pulse coincident with the hit of an errored or timed-out access
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset (nRST=0, asynchronous): state=IDLE; all outputs 0; latched request registers 0; timeout counter 0. Reset mid-access aborts the access with no hit.
- States: IDLE, IACC, DACC, RESP.
- IDLE, arbitration:
  - dWEN|dREN -> DACC. Data port has priority over the instruction port.
  - else iREN & !halt -> IACC.
  - On the transition edge, latch addr, store, the write flag (dWEN) and the port (I/D).
  - dWEN & dREN together: treated as a write; dREN ignored.
- IACC/DACC:
  - ramaddr = latched addr.
  - ramREN=1 for IACC or a data read; ramWEN=1 for a data write; ramstore = latched store.
  - Ram outputs are driven only from latched registers, never from live inputs.
  - Counter increments each cycle in the state.
- Exit from IACC/DACC:
  - ramstate==ACCESS -> RESP; capture ramload into the load register (reads only).
  - ramstate==ERROR -> RESP with load=ERRWORD and error flag set.
  - counter reaches TIMEOUT-1 without ACCESS -> RESP with error flag set.
  - FREE/BUSY otherwise -> stay.
- RESP:
  - ram enables 0.
  - ihit or dhit=1 per latched port; iload/dload = load register.
  - merr=1 if error flag set.
  - Counter cleared; next state IDLE unconditionally.
- Latency: request seen in IDLE at cycle N, RAM ACCESS at N+1 -> hit at N+2 (minimum). Each additional BUSY cycle adds one.
- Outputs are registered/state-decoded only; no combinational path from request inputs to hit.
- Requests are ignored outside IDLE.
- Requester must drop its request on the hit cycle. A request still held when IDLE is re-entered starts a new access.
- Request withdrawn mid-access: the access completes and the hit still pulses.
- Write response: dhit=1, dload=0.
- iload/dload hold 0 when their hit is low.
- Back-to-back: IDLE occupies at least one cycle between accesses, giving a 3-cycle minimum period.
- halt=1 blocks new IACC entry only; an in-flight fetch and data accesses still complete.
- Counter width is $clog2(TIMEOUT+1); it saturates and does not wrap.

Decomposition:
- ramstate_t (FREE, BUSY, ACCESS, ERROR) and word_t live in cpu_types_pkg.
- arb_state_t (IDLE, IACC, DACC, RESP) goes in dp_types_pkg.
- Interface bundle memory_arbiter_if with modport arb, plus tb modport.
- No sub-module; the timeout counter is inline.

Test Plan:
1. Fetch: iREN=1, iaddr=0x0000_0040, ramstate=ACCESS, ramload=0x2402_0005 -> ramREN=1 and ramaddr=0x40 at N+1; ihit=1, iload=0x2402_0005 at N+2; one pulse only.
2. Priority: iREN=1, dREN=1, daddr=0x100 in the same cycle, RAM returns 0xCAFE_F00D -> DACC first, dhit with dload=0xCAFE_F00D; ihit follows at least 3 cycles later.
3. Write with 2 BUSY cycles: dWEN=1, daddr=0x80, dstore=0x1234_5678, then BUSY, BUSY, ACCESS -> ramWEN=1 and ramstore=0x1234_5678 held 3 cycles; dhit=1, dload=0 at N+4; merr=0.
4. Error and timeout:
   - ramstate=ERROR on a read -> dhit=1, dload=0xBAD1BAD1, merr=1.
   - TIMEOUT=4 with ramstate stuck BUSY -> ihit and merr after exactly 4 access cycles.
5. Halt: halt=1, iREN=1 -> no ramREN for 10 cycles. A dREN issued meanwhile is still serviced.
6. Reset mid-access: nRST low during DACC -> ram enables 0 immediately (asynchronous); no dhit after release; state IDLE.
